rx_packet_ctrl: RTL and testbench

RX_PACKET_CTRL -- requirements
Module: rx_packet_ctrl

---
 rtl/rx_packet_ctrl.sv | 103 ++++++++++
 tb/tb_rx_packet_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_packet_ctrl.sv
// rx_packet_ctrl: receive-side packet framer: SYNC hunt, PID check, LSB-first byte assembly,
// EOP qualification and one-cycle done/error reporting.
module rx_packet_ctrl (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       raw_bit,
  input  logic       raw_valid,
  input  logic       in_bit,
  input  logic       bit_valid,
  input  logic       se0,
  output logic       rx_en,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       pid_valid,
  output logic [6:0] byte_cnt,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic [1:0] err_code
);
  typedef enum logic [2:0] {HUNT, PID, DATA, EOP, DONE, ERR} state_t;
  state_t r_state, w_next;
  logic [7:0] r_sync, r_shift, r_byte_out, w_byte;
  logic [6:0] r_byte_cnt;
  logic [2:0] r_bit_cnt;
  logic [1:0] r_eop_cnt, r_err_code, w_err;
  logic r_byte_valid, r_pid_valid;
  logic w_shift, w_byte_done, w_pid_ok, w_accept;
  assign w_byte      = {in_bit, r_shift[7:1]};
  assign w_shift     = (r_state == PID || r_state == DATA) && bit_valid && !se0;
  assign w_byte_done = w_shift && r_bit_cnt == 3'd7;
  assign w_pid_ok    = w_byte[3:0] == ~w_byte[7:4];
  always_comb begin
    w_next   = r_state;
    w_err    = 2'd0;
    w_accept = 1'b0;
    case (r_state)
      HUNT: w_next = (r_sync == 8'h80) ? PID : HUNT;
      PID, DATA:
        if (se0) begin
          // a clean EOP needs byte alignment and at least one payload byte after the PID
          w_next = (r_state == DATA && r_bit_cnt == 3'd0 && r_byte_cnt >= 7'd2) ? EOP : ERR;
          w_err  = 2'd1;
        end else if (w_byte_done) begin
          if (r_state == PID) begin
            w_next = w_pid_ok ? DATA : ERR;
            w_err  = 2'd0;
          end else begin
            w_next = (r_byte_cnt >= 7'd67) ? ERR : DATA;
            w_err  = 2'd3;
          end
          w_accept = w_next != ERR;
        end
      EOP: begin
        w_next = se0 ? ((r_eop_cnt == 2'd3) ? ERR : EOP) : ((r_eop_cnt >= 2'd2) ? DONE : ERR);
        w_err  = 2'd2;
      end
      default: w_next = HUNT;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= HUNT;
      r_sync       <= 8'h00;
      r_shift      <= 8'h00;
      r_byte_out   <= 8'h00;
      r_byte_cnt   <= 7'd0;
      r_bit_cnt    <= 3'd0;
      r_eop_cnt    <= 2'd0;
      r_err_code   <= 2'd0;
      r_byte_valid <= 1'b0;
      r_pid_valid  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_byte_valid <= w_accept;
      r_pid_valid  <= w_accept && r_state == PID;
      r_eop_cnt    <= (r_state == EOP) ? r_eop_cnt + 2'd1 : 2'd1;
      if (w_next == ERR) r_err_code <= w_err;
      if (r_state == HUNT && raw_valid) r_sync <= {raw_bit, r_sync[7:1]};
      if (w_shift) begin
        r_shift   <= w_byte;
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_accept) begin
        r_byte_out <= w_byte;
        r_byte_cnt <= r_byte_cnt + 7'(r_byte_cnt != 7'h7f);
      end
      if (r_state == HUNT && w_next == PID) r_byte_cnt <= 7'd0;
      if (r_state == DONE || r_state == ERR) begin
        r_sync    <= 8'h00;
        r_shift   <= 8'h00;
        r_bit_cnt <= 3'd0;
      end
    end
  end
  assign rx_en      = r_state == PID || r_state == DATA;
  assign byte_out   = r_byte_out;
  assign byte_valid = r_byte_valid;
  assign pid_valid  = r_pid_valid;
  assign byte_cnt   = r_byte_cnt;
  assign pkt_done   = r_state == DONE;
  assign pkt_err    = r_state == ERR;
  assign err_code   = r_err_code;
endmodule

// File: tb/tb_rx_packet_ctrl.sv
// tb_rx_packet_ctrl: directed packets with hand-computed expectations; a negedge monitor
// tallies output strobes that the main sequence then checks.
module tb_rx_packet_ctrl;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic raw_bit = 1'b0, raw_valid = 1'b0, in_bit = 1'b0, bit_valid = 1'b0, se0 = 1'b0;
  logic rx_en, byte_valid, pid_valid, pkt_done, pkt_err;
  logic [7:0] byte_out;
  logic [6:0] byte_cnt;
  logic [1:0] err_code;
  int n_vec = 0, n_bad = 0;
  int n_bv, n_pid, n_done, n_err, n_both, n_stray;
  logic [7:0] last_byte, pid_byte;
  logic [1:0] last_err;

  rx_packet_ctrl dut (
    .clock(clock), .reset_n(reset_n), .raw_bit(raw_bit), .raw_valid(raw_valid),
    .in_bit(in_bit), .bit_valid(bit_valid), .se0(se0), .rx_en(rx_en),
    .byte_out(byte_out), .byte_valid(byte_valid), .pid_valid(pid_valid),
    .byte_cnt(byte_cnt), .pkt_done(pkt_done), .pkt_err(pkt_err), .err_code(err_code)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (byte_valid) begin
      n_bv++;
      last_byte = byte_out;
      if (!rx_en) n_stray++;
    end
    if (pid_valid) begin
      n_pid++;
      pid_byte = byte_out;
    end
    if (pkt_done) n_done++;
    if (pkt_err) begin
      n_err++;
      last_err = err_code;
    end
    if (pkt_done && pkt_err) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    @(posedge clock);
    #1;
    n_bv = 0; n_pid = 0; n_done = 0; n_err = 0;
    last_byte = 8'h00; pid_byte = 8'h00; last_err = 2'd0;
  endtask

  task automatic drive(input logic rv, input logic rb, input logic bv, input logic b, input logic s);
    @(negedge clock);
    raw_valid = rv; raw_bit = rb; bit_valid = bv; in_bit = b; se0 = s;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask

  task automatic send_sync();
    for (int i = 0; i < 7; i++) drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    idle(2);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_at);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, b[i], 0);
      if (i == gap_at) idle(1);
    end
  endtask

  task automatic send_se0(input int n);
    repeat (n) drive(0, 0, 0, 0, 1);
    idle(3);
  endtask

  initial begin
    n_both = 0; n_stray = 0;
    #2 reset_n = 1'b0;
    #1;
    check("reset_ctl", {rx_en, byte_valid, pid_valid, pkt_done, pkt_err, err_code}, 0);
    check("reset_byte_out", byte_out, 8'h00);
    check("reset_byte_cnt", byte_cnt, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    clr();

    send_sync();
    check("good_rx_en_on", rx_en, 1);
    send_byte(8'hC3, 8);
    send_byte(8'hA5, 8);
    send_se0(2);
    check("good_pid_cnt", n_pid, 1);
    check("good_pid_byte", pid_byte, 8'hC3);
    check("good_bv_cnt", n_bv, 2);
    check("good_data", last_byte, 8'hA5);
    check("good_byte_cnt", byte_cnt, 2);
    check("good_done", n_done, 1);
    check("good_err", n_err, 0);
    check("good_rx_en_off", rx_en, 0);

    clr();
    send_sync();
    send_byte(8'hC3, 8);
    repeat (3) drive(0, 0, 1, 1, 0);
    send_se0(1);
    check("align_err", n_err, 1);
    check("align_code", last_err, 1);

    clr();
    send_sync();
    send_byte(8'hC4, 8);
    idle(3);
    check("badpid_err", n_err, 1);
    check("badpid_code", last_err, 0);
    check("badpid_bv", n_bv, 0);
    check("badpid_pid", n_pid, 0);
    check("badpid_hunt", rx_en, 0);

    clr();
    send_sync();
    send_byte(8'hC3, 8);
    send_byte(8'hFF, 5);
    send_se0(2);
    check("stuff_bv_cnt", n_bv, 2);
    check("stuff_data", last_byte, 8'hFF);
    check("stuff_done", n_done, 1);
    check("stuff_err", n_err, 0);

    clr();
    send_sync();
    send_byte(8'hC3, 8);
    send_byte(8'h3C, 8);
    send_se0(1);
    check("eop1_err", n_err, 1);
    check("eop1_code", last_err, 2);
    check("eop1_done", n_done, 0);

    clr();
    send_sync();
    send_byte(8'hC3, 8);
    send_byte(8'h3C, 8);
    send_se0(4);
    check("eop4_err", n_err, 1);
    check("eop4_code", last_err, 2);
    check("eop4_done", n_done, 0);

    clr();
    send_sync();
    send_byte(8'hC3, 8);
    send_byte(8'h3C, 8);
    send_se0(3);
    check("eop3_done", n_done, 1);
    check("eop3_err", n_err, 0);

    clr();
    send_sync();
    send_byte(8'hC3, 8);
    for (int i = 0; i < 67; i++) send_byte(8'(i), 8);
    idle(3);
    check("ovf_bv_cnt", n_bv, 67);
    check("ovf_last_data", last_byte, 8'd65);
    check("ovf_err", n_err, 1);
    check("ovf_code", last_err, 3);
    check("ovf_byte_cnt", byte_cnt, 67);

    clr();
    send_sync();
    send_byte(8'hC3, 8);
    repeat (4) drive(0, 0, 1, 1, 0);
    @(negedge clock);
    bit_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_reset_ctl", {rx_en, byte_valid, pid_valid, pkt_done, pkt_err, err_code}, 0);
    check("mid_reset_byte_out", byte_out, 8'h00);
    check("mid_reset_byte_cnt", byte_cnt, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    send_sync();
    send_byte(8'hC3, 8);
    idle(1);
    check("restart_pid_valid", pid_valid, 1);
    check("restart_byte_cnt", byte_cnt, 1);
    send_byte(8'h5A, 8);
    send_se0(2);
    check("restart_done", n_done, 1);
    check("restart_err", n_err, 0);
    check("restart_data", last_byte, 8'h5A);

    check("done_err_overlap", n_both, 0);
    check("bv_outside_body", n_stray, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
